// File: rtl/load_store_unit_if.sv
// Word-organised data-memory bus between the load/store unit (master) and
// the data memory (slave): one strobe at a time, completed by mem_ready.
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-3:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_addr, mem_read, mem_write, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_read, mem_write, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/load_store_unit.sv
// MIPS load/store unit: lane extraction with sign/zero extension on loads,
// read-modify-write for sb/sh over a whole-word memory port.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [5:0]               opcode,
  input  logic [ADDR_W-1:0]        address,
  input  logic [31:0]              write_data,
  output logic [31:0]              load_data,
  output logic                     busy,
  output logic                     done,
  output logic                     misaligned,
  load_store_unit_if.master        mem
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR} state_t;

  state_t             state_q, state_d;
  logic [5:0]         opcode_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [15:0]        data_q;
  logic [31:0]        wdata_q;

  logic req_known, req_load, req_sw, req_rmw, req_misaligned, accept;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_ext;
  logic [31:0] merged;

  // Request decode works on the live inputs; the decision is made on the
  // same edge that latches them.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    req_known      = 1'b1;
    req_load       = 1'b0;
    req_sw         = 1'b0;
    req_rmw        = 1'b0;
    req_misaligned = 1'b0;
    case (opcode)
      OP_LB, OP_LBU: req_load = 1'b1;
      OP_LH, OP_LHU: begin req_load = 1'b1; req_misaligned = address[0];      end
      OP_LW:         begin req_load = 1'b1; req_misaligned = |address[1:0];   end
      OP_SB:         req_rmw = 1'b1;
      OP_SH:         begin req_rmw  = 1'b1; req_misaligned = address[0];      end
      OP_SW:         begin req_sw   = 1'b1; req_misaligned = |address[1:0];   end
      default:       req_known = 1'b0;
    endcase
  end

  assign accept = (state_q == IDLE) && start;

  // State register
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start && req_known && !req_misaligned) begin
          if (req_load)    state_d = LOAD;
          else if (req_sw) state_d = STORE;
          else if (req_rmw) state_d = RMW_RD;
        end
      end
      LOAD, STORE, RMW_WR: if (mem.mem_ready) state_d = IDLE;
      RMW_RD:              if (mem.mem_ready) state_d = RMW_WR;
      default:             state_d = IDLE;
    endcase
  end

  // Strobe and stall outputs
  always_comb begin
    mem.mem_read  = 1'b0;
    mem.mem_write = 1'b0;
    busy          = 1'b1;
    unique case (state_q)
      IDLE:          busy          = 1'b0;
      LOAD, RMW_RD:  mem.mem_read  = 1'b1;
      STORE, RMW_WR: mem.mem_write = 1'b1;
      default:       busy          = 1'b0;
    endcase
  end

  // Little-endian lane selection from the returned word
  assign byte_lane = mem.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign half_lane = addr_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];

  always_comb begin
    unique case (opcode_q)
      OP_LB:   load_ext = {{24{byte_lane[7]}}, byte_lane};
      OP_LBU:  load_ext = {24'd0, byte_lane};
      OP_LH:   load_ext = {{16{half_lane[15]}}, half_lane};
      OP_LHU:  load_ext = {16'd0, half_lane};
      default: load_ext = mem.mem_rdata;
    endcase
  end

  always_comb begin
    merged = mem.mem_rdata;
    if (opcode_q == OP_SB) merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
    else                   merged[{addr_q[1], 4'b0000} +: 16] = data_q;
  end

  // Request latches, write word, load result and completion pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q   <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wdata_q    <= '0;
      load_data  <= '0;
      done       <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      done       <= 1'b0;
      misaligned <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            opcode_q <= opcode;
            addr_q   <= address;
            data_q   <= write_data[15:0];
            if (req_sw && !req_misaligned) wdata_q <= write_data;
            // Rejected requests complete immediately without touching memory.
            if (!req_known || req_misaligned) begin
              done       <= 1'b1;
              misaligned <= req_known;
            end
          end
        end
        LOAD: begin
          if (mem.mem_ready) begin
            load_data <= load_ext;
            done      <= 1'b1;
          end
        end
        RMW_RD:        if (mem.mem_ready) wdata_q <= merged;
        STORE, RMW_WR: if (mem.mem_ready) done    <= 1'b1;
        default: ;
      endcase
    end
  end

  assign mem.mem_addr  = addr_q[ADDR_W-1:2];
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized traffic
// against a byte-lane arithmetic model of a 16-word memory.
module tb_load_store_unit;

  localparam int ADDR_W = 32;
  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24,
                         LHU = 6'h25, SB = 6'h28, SH = 6'h29, SW = 6'h2B;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [5:0]        opcode;
  logic [ADDR_W-1:0] address;
  logic [31:0]       write_data;
  logic [31:0]       load_data;
  logic              busy, done, misaligned;

  int passed = 0;
  int total  = 0;

  logic [31:0] ref_mem [16];
  logic [31:0] last_load;

  load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .opcode     (opcode),
    .address    (address),
    .write_data (write_data),
    .load_data  (load_data),
    .busy       (busy),
    .done       (done),
    .misaligned (misaligned),
    .mem        (bus.master)
  );

  always #5 clk = ~clk;

  // Read data always reflects the model memory at the presented word index.
  assign bus.mem_rdata = ref_mem[bus.mem_addr[3:0]];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 0 unknown, 1 misaligned, 2 load, 3 sw, 4 sb/sh
  function automatic int classify(input logic [5:0] op, input int a);
    int size;
    int kind;
    case (op)
      LB, LBU: begin size = 1; kind = 2; end
      LH, LHU: begin size = 2; kind = 2; end
      LW:      begin size = 4; kind = 2; end
      SB:      begin size = 1; kind = 4; end
      SH:      begin size = 2; kind = 4; end
      SW:      begin size = 4; kind = 3; end
      default: begin size = 1; kind = 0; end
    endcase
    if (kind != 0 && (a % size) != 0) kind = 1;
    return kind;
  endfunction

  function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] word, input int a);
    longint v;
    longint w;
    w = longint'(word);
    case (op)
      LB, LBU: v = (w >> (8 * (a % 4))) & 'hFF;
      LH, LHU: v = (w >> (16 * ((a / 2) % 2))) & 'hFFFF;
      default: v = w;
    endcase
    if (op == LB && v >= 128)   v = v - 256;
    if (op == LH && v >= 32768) v = v - 65536;
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_store(input logic [5:0] op, input logic [31:0] old,
                                            input int a, input logic [31:0] data);
    logic [31:0] mask;
    int          sh;
    if (op == SB) begin mask = 32'hFF;   sh = 8 * (a % 4); end
    else          begin mask = 32'hFFFF; sh = 16 * ((a / 2) % 2); end
    return (old & ~(mask << sh)) | ((data & mask) << sh);
  endfunction

  // One memory beat: holds mem_ready low for 'waits' cycles, then completes.
  // Spurious start pulses with junk requests are thrown in while busy.
  task automatic beat(input string tag, input bit is_write, input logic [29:0] exp_addr,
                      input logic [31:0] exp_wdata, input int waits);
    for (int i = 0; i <= waits; i++) begin
      bus.mem_ready = (i == waits);
      check({tag, " mem_read"},  32'(bus.mem_read),  32'(!is_write));
      check({tag, " mem_write"}, 32'(bus.mem_write), 32'(is_write));
      check({tag, " mem_addr"},  32'(bus.mem_addr),  32'(exp_addr));
      check({tag, " busy"},      32'(busy),          32'd1);
      check({tag, " done"},      32'(done),          32'd0);
      if (is_write) check({tag, " mem_wdata"}, bus.mem_wdata, exp_wdata);
      if (i < waits) begin
        start      = 1'($urandom_range(0, 1));
        opcode     = 6'($urandom);
        address    = $urandom;
        write_data = $urandom;
      end
      tick();
    end
    bus.mem_ready = 1'b0;
    start         = 1'b0;
  endtask

  // Full transaction starting in the current cycle; ends in the done cycle.
  task automatic run_op(input string tag, input logic [5:0] op, input int a,
                        input logic [31:0] data, input int wr, input int ww);
    int          kind;
    int          idx;
    logic [31:0] exp;
    kind = classify(op, a);
    idx  = (a / 4) % 16;
    start      = 1'b1;
    opcode     = op;
    address    = 32'(a);
    write_data = data;
    tick();
    start = 1'b0;
    case (kind)
      2: begin
        exp = ref_load(op, ref_mem[idx], a);
        beat({tag, " rd"}, 1'b0, 30'(idx), 32'd0, wr);
        last_load = exp;
      end
      3: begin
        beat({tag, " wr"}, 1'b1, 30'(idx), data, ww);
        ref_mem[idx] = data;
      end
      4: begin
        exp = ref_store(op, ref_mem[idx], a, data);
        beat({tag, " rmw rd"}, 1'b0, 30'(idx), 32'd0, wr);
        beat({tag, " rmw wr"}, 1'b1, 30'(idx), exp, ww);
        ref_mem[idx] = exp;
      end
      default: begin
        check({tag, " no read"},  32'(bus.mem_read),  32'd0);
        check({tag, " no write"}, 32'(bus.mem_write), 32'd0);
      end
    endcase
    check({tag, " done"},       32'(done),       32'd1);
    check({tag, " busy"},       32'(busy),       32'd0);
    check({tag, " misaligned"}, 32'(misaligned), 32'(kind == 1));
    check({tag, " load_data"},  load_data,       last_load);
  endtask

  initial begin
    logic [5:0] ops [9];
    logic [5:0] op;
    ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW, 6'h00};

    for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
    rst_n         = 1'b0;
    start         = 1'b0;
    opcode        = '0;
    address       = '0;
    write_data    = '0;
    bus.mem_ready = 1'b0;
    last_load     = '0;
    #12;
    check("reset load_data",  load_data,                32'd0);
    check("reset busy",       32'(busy),                32'd0);
    check("reset done",       32'(done),                32'd0);
    check("reset misaligned", 32'(misaligned),          32'd0);
    check("reset mem_read",   32'(bus.mem_read),        32'd0);
    check("reset mem_write",  32'(bus.mem_write),       32'd0);
    check("reset mem_addr",   32'(bus.mem_addr),        32'd0);
    check("reset mem_wdata",  bus.mem_wdata,            32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Word load and lane extraction from word 3
    ref_mem[3] = 32'h8899AABB;
    run_op("lw 0x0C", LW, 'h0C, 32'd0, 0, 0);
    check("lw value", load_data, 32'h8899AABB);
    run_op("lb 0x0D", LB, 'h0D, 32'd0, 0, 0);
    check("lb value", load_data, 32'hFFFFFFAA);
    run_op("lbu 0x0D", LBU, 'h0D, 32'd0, 0, 0);
    check("lbu value", load_data, 32'h000000AA);
    run_op("lh 0x0E", LH, 'h0E, 32'd0, 0, 0);
    check("lh value", load_data, 32'hFFFF8899);
    run_op("lhu 0x0E", LHU, 'h0E, 32'd0, 0, 0);
    check("lhu value", load_data, 32'h00008899);

    // Byte store as read-modify-write
    ref_mem[0] = 32'h11223344;
    run_op("sb 0x02", SB, 'h02, 32'h000000FD, 0, 0);
    check("sb word", ref_mem[0], 32'h11FD3344);

    // Halfword store with two wait cycles on each beat
    ref_mem[1] = 32'hAAAAAAAA;
    run_op("sh 0x06", SH, 'h06, 32'h000003F3, 2, 2);
    check("sh word", ref_mem[1], 32'h03F3AAAA);

    // Rejected requests
    run_op("lw 0x01", LW, 'h01, 32'd0, 0, 0);
    run_op("op 0x00", 6'h00, 'h04, 32'd0, 0, 0);

    // Reset during the read beat of an sb
    start      = 1'b1;
    opcode     = SB;
    address    = 32'h8;
    write_data = 32'h55;
    tick();
    start = 1'b0;
    check("abort mem_read before", 32'(bus.mem_read), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort mem_read drop", 32'(bus.mem_read), 32'd0);
    check("abort busy drop",     32'(busy),         32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort no write", 32'(bus.mem_write), 32'd0);
      check("abort no done",  32'(done),          32'd0);
    end
    rst_n     = 1'b1;
    last_load = '0;
    tick();
    check("abort after write", 32'(bus.mem_write), 32'd0);
    run_op("lw after abort", LW, 'h08, 32'd0, 1, 0);

    // Randomized back-to-back traffic
    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 8)];
      run_op($sformatf("rand%0d op%h", n, op), op, int'($urandom_range(0, 63)),
             $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
